// File: rtl/bist_pkg.sv
// Shared encodings and sizing helpers for the BIST run sequencer and its signature comparator.
package bist_pkg;

    localparam int REG_W_DEF   = 16;
    localparam int NUM_PAT_DEF = 8;
    localparam int SETTLE_DEF  = 4;
    localparam int FAIL_W      = 8;

    localparam logic [FAIL_W-1:0] FAIL_MAX = {FAIL_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_UNLOAD  = 3'd5,
        ST_DONE    = 3'd6
    } bist_state_e;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The pattern index must also reach NUM_PAT, the ROM slot holding the last golden value.
    function automatic int pat_w(input int num_pat);
        return cnt_w(num_pat + 1);
    endfunction

endpackage

// File: rtl/bist_seq_ctrl_if.sv
// Bundle between the BIST sequencer (master) and the chain, pattern ROM and JTAG status logic (slave).
interface bist_seq_ctrl_if
    import bist_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int PAT_W = pat_w(NUM_PAT_DEF)
);

    logic              Start;
    logic              Abort;
    logic [PAT_W-1:0]  Pat_idx;
    logic [REG_W-1:0]  Stim_vec;
    logic [REG_W-1:0]  Gold_vec;
    logic              Chain_si;
    logic              Chain_so;
    logic              Test_Log_Res;
    logic              Shift_DR;
    logic              BIST_Sh_t_clk;
    logic              BIST_Com_t_clk;
    logic              Busy;
    logic              Done;
    logic              Pass;
    logic [FAIL_W-1:0] Fail_cnt;

    modport master (
        input  Start, Abort, Stim_vec, Gold_vec, Chain_so,
        output Pat_idx, Chain_si, Test_Log_Res, Shift_DR, BIST_Sh_t_clk, BIST_Com_t_clk,
               Busy, Done, Pass, Fail_cnt
    );

    modport slave (
        output Start, Abort, Stim_vec, Gold_vec, Chain_so,
        input  Pat_idx, Chain_si, Test_Log_Res, Shift_DR, BIST_Sh_t_clk, BIST_Com_t_clk,
               Busy, Done, Pass, Fail_cnt
    );

endinterface

// File: rtl/bist_sig_cmp.sv
// Bit-serial response comparator with a saturating mismatch counter.
module bist_sig_cmp
    import bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic              sample_bit,
    input  logic              gold_bit,
    output logic [FAIL_W-1:0] fail_cnt
);

    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;

    // Clear wins over a compare in the same cycle; the count sticks at its maximum.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (clear) begin
            fail_cnt_d = '0;
        end else if (enable && (sample_bit != gold_bit) && (fail_cnt_q != FAIL_MAX)) begin
            fail_cnt_d = fail_cnt_q + FAIL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt_q <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/bist_seq_ctrl.sv
// Sequences one BIST run: clear, shift/settle/capture per pattern, final unload, result report.
module bist_seq_ctrl
    import bist_pkg::*;
#(
    parameter int REG_W   = REG_W_DEF,
    parameter int NUM_PAT = NUM_PAT_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic TCK,
    input  logic TRST_n,
    bist_seq_ctrl_if.master bus
);

    localparam int BIT_W = cnt_w(REG_W);
    localparam int SET_W = cnt_w(SETTLE);
    localparam int PAT_W = pat_w(NUM_PAT);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(REG_W - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT - 1);

    bist_state_e       state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [PAT_W-1:0]  pat_idx_q, pat_idx_d;
    logic              aborted_q, aborted_d;
    logic              pass_q, pass_d;

    logic              cmp_clear;
    logic              cmp_en;
    logic              run_ok;
    logic [BIT_W-1:0]  stim_sel;
    logic [FAIL_W-1:0] fail_cnt;

    always_ff @(posedge TCK) begin
        if (!TRST_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            pat_idx_q    <= '0;
            aborted_q    <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            pat_idx_q    <= pat_idx_d;
            aborted_q    <= aborted_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;
        pat_idx_d    = pat_idx_q;
        aborted_d    = aborted_q;
        pass_d       = pass_q;
        cmp_clear    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d   = ST_CLEAR;
                    pat_idx_d = '0;
                    aborted_d = 1'b0;
                end
            end
            // An Abort arriving here is folded into the clear already under way.
            ST_CLEAR: begin
                bit_cnt_d    = '0;
                settle_cnt_d = '0;
                pat_idx_d    = '0;
                if (aborted_q || bus.Abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT, ST_UNLOAD: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = (state_q == ST_SHIFT) ? ST_SETTLE : ST_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SET_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = ST_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            ST_CAPTURE: begin
                pat_idx_d = pat_idx_q + PAT_W'(1);
                state_d   = (pat_idx_q == PAT_LAST) ? ST_UNLOAD : ST_SHIFT;
            end
            ST_DONE: begin
                pass_d  = run_ok;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.Abort && (state_q inside {ST_SHIFT, ST_SETTLE, ST_CAPTURE, ST_UNLOAD})) begin
            state_d      = ST_CLEAR;
            aborted_d    = 1'b1;
            bit_cnt_d    = '0;
            settle_cnt_d = '0;
            pat_idx_d    = '0;
        end

        // Result and mismatch count already read zero while the CLEAR cycle is on the bus.
        if (state_d == ST_CLEAR) begin
            cmp_clear = 1'b1;
            pass_d    = 1'b0;
        end
    end

    always_comb begin
        stim_sel = BIT_LAST - bit_cnt_q;
        cmp_en   = (state_q == ST_UNLOAD) || ((state_q == ST_SHIFT) && (pat_idx_q != '0));
        run_ok   = (fail_cnt == '0) && !aborted_q;
    end

    bist_sig_cmp u_sig_cmp (
        .clk        (TCK),
        .rst_n      (TRST_n),
        .clear      (cmp_clear),
        .enable     (cmp_en),
        .sample_bit (bus.Chain_so),
        .gold_bit   (bus.Gold_vec[bit_cnt_q]),
        .fail_cnt   (fail_cnt)
    );

    assign bus.Pat_idx        = pat_idx_q;
    assign bus.Chain_si       = (state_q == ST_SHIFT) ? bus.Stim_vec[stim_sel] : 1'b0;
    assign bus.Test_Log_Res   = (state_q == ST_CLEAR);
    assign bus.Shift_DR       = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
    assign bus.BIST_Sh_t_clk  = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
    assign bus.BIST_Com_t_clk = (state_q == ST_CAPTURE);
    assign bus.Busy           = (state_q != ST_IDLE);
    assign bus.Done           = (state_q == ST_DONE);
    assign bus.Pass           = (state_q == ST_DONE) ? run_ok : pass_q;
    assign bus.Fail_cnt       = fail_cnt;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Directed bench: two sequencers (8 and 20 patterns) each driving a behavioural 16-bit chain model.
module tb_bist_seq_ctrl;
    import bist_pkg::*;

    localparam int REG_W  = 16;
    localparam int SETTLE = 4;

    logic       tck;
    logic       trst_n;
    logic [1:0] start_r;
    logic [1:0] abort_r;

    logic [15:0] stim_rom [32];
    logic [15:0] gold_rom [2][32];

    logic [1:0] busy_w, done_w, pass_w, tlr_w, sdr_w, sh_w, com_w, si_w;
    logic [7:0] fail_w [2];
    logic [4:0] pidx_w [2];

    int total = 0;
    int bad   = 0;

    // Logic under test: rotate then xor, applied on each capture strobe.
    function automatic logic [15:0] lut(input logic [15:0] x);
        return {x[10:0], x[15:11]} ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] bitrev16(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = x[15-i];
        return r;
    endfunction

    // Chain shifts in at cell 0 and out of cell 15, so the response leaves in reversed order.
    function automatic logic [15:0] exp_gold(input logic [15:0] stim);
        return bitrev16(lut(stim));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NP = (g == 0) ? 8 : 20;

        bist_seq_ctrl_if #(.REG_W(REG_W), .PAT_W(pat_w(NP))) bus ();

        logic [15:0] chain_q;
        logic [4:0]  pi5;

        bist_seq_ctrl #(.REG_W(REG_W), .NUM_PAT(NP), .SETTLE(SETTLE)) u_dut (
            .TCK    (tck),
            .TRST_n (trst_n),
            .bus    (bus)
        );

        assign pi5          = 5'(bus.Pat_idx);
        assign bus.Start    = start_r[g];
        assign bus.Abort    = abort_r[g];
        assign bus.Stim_vec = (pi5 < 5'(NP)) ? stim_rom[pi5] : 16'h0000;
        assign bus.Gold_vec = (pi5 == 5'd0) ? 16'h0000 : gold_rom[g][pi5 - 5'd1];
        assign bus.Chain_so = chain_q[15];

        always @(posedge tck) begin
            if (!trst_n || bus.Test_Log_Res) chain_q <= '0;
            else if (bus.Shift_DR && bus.BIST_Sh_t_clk) chain_q <= {chain_q[14:0], bus.Chain_si};
            else if (bus.BIST_Com_t_clk) chain_q <= lut(chain_q);
        end

        assign busy_w[g] = bus.Busy;
        assign done_w[g] = bus.Done;
        assign pass_w[g] = bus.Pass;
        assign tlr_w[g]  = bus.Test_Log_Res;
        assign sdr_w[g]  = bus.Shift_DR;
        assign sh_w[g]   = bus.BIST_Sh_t_clk;
        assign com_w[g]  = bus.BIST_Com_t_clk;
        assign si_w[g]   = bus.Chain_si;
        assign fail_w[g] = bus.Fail_cnt;
        assign pidx_w[g] = pi5;
    end

    initial tck = 1'b0;
    always #5 tck = ~tck;

    // Leaves the caller at the negedge after Start was sampled, i.e. inside CLEAR.
    task automatic start_pulse(input int g);
        @(negedge tck);
        start_r[g] = 1'b1;
        @(negedge tck);
        start_r[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int lat0, output int lat, output bit timeout);
        lat = lat0;
        while (!done_w[g] && lat < 1000) begin
            @(negedge tck);
            lat++;
        end
        timeout = !done_w[g];
    endtask

    task automatic test_reset();
        trst_n = 1'b0;
        repeat (3) @(negedge tck);
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy_w[0]); end
        total++; if (done_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done_w[0]); end
        total++; if (pass_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL reset_pass got=%b want=0", pass_w[0]); end
        total++; if (fail_w[0] !== 8'd0) begin bad++; $display("[TB] FAIL reset_fail_cnt got=%0d want=0", fail_w[0]); end
        total++; if (pidx_w[0] !== 5'd0) begin bad++; $display("[TB] FAIL reset_pat_idx got=%0d want=0", pidx_w[0]); end
        total++; if ({tlr_w[0], sdr_w[0], sh_w[0], com_w[0], si_w[0]} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b want=00000", {tlr_w[0], sdr_w[0], sh_w[0], com_w[0], si_w[0]});
        end
        trst_n = 1'b1;
        repeat (2) @(negedge tck);
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%b want=0", busy_w[0]); end
    endtask

    task automatic test_loopback();
        int lat; bit to; logic [15:0] s;
        s = stim_rom[0];
        start_pulse(0);
        total++; if (tlr_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL clear_tlr got=%b want=1", tlr_w[0]); end
        total++; if (busy_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL clear_busy got=%b want=1", busy_w[0]); end
        @(negedge tck);
        total++; if ({sdr_w[0], sh_w[0], si_w[0]} !== {2'b11, s[15]}) begin
            bad++; $display("[TB] FAIL shift0 got=%b want=%b", {sdr_w[0], sh_w[0], si_w[0]}, {2'b11, s[15]});
        end
        @(negedge tck);
        total++; if (si_w[0] !== s[14]) begin bad++; $display("[TB] FAIL shift1_si got=%b want=%b", si_w[0], s[14]); end
        wait_done(0, 3, lat, to);
        total++; if (to || lat != 186) begin bad++; $display("[TB] FAIL loop_latency got=%0d want=186", lat); end
        total++; if (pass_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL loop_pass got=%b want=1", pass_w[0]); end
        total++; if (fail_w[0] !== 8'd0) begin bad++; $display("[TB] FAIL loop_fail_cnt got=%0d want=0", fail_w[0]); end
        total++; if (busy_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL loop_busy_at_done got=%b want=1", busy_w[0]); end
        @(negedge tck);
        total++; if ({busy_w[0], done_w[0]} !== 2'b00) begin
            bad++; $display("[TB] FAIL loop_after_done got=%b want=00", {busy_w[0], done_w[0]});
        end
        repeat (3) @(negedge tck);
        total++; if (pass_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL loop_pass_sticky got=%b want=1", pass_w[0]); end
    endtask

    task automatic test_gold_flip();
        int lat; bit to;
        gold_rom[0][3] = gold_rom[0][3] ^ 16'h0020;
        start_pulse(0);
        wait_done(0, 1, lat, to);
        total++; if (to || lat != 186) begin bad++; $display("[TB] FAIL flip_latency got=%0d want=186", lat); end
        total++; if (pass_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL flip_pass got=%b want=0", pass_w[0]); end
        total++; if (fail_w[0] !== 8'd1) begin bad++; $display("[TB] FAIL flip_fail_cnt got=%0d want=1", fail_w[0]); end
        gold_rom[0][3] = gold_rom[0][3] ^ 16'h0020;
        @(negedge tck);
    endtask

    task automatic test_saturate();
        int lat; bit to;
        start_pulse(1);
        wait_done(1, 1, lat, to);
        total++; if (to || lat != 438) begin bad++; $display("[TB] FAIL sat_latency got=%0d want=438", lat); end
        total++; if (fail_w[1] !== 8'd255) begin bad++; $display("[TB] FAIL sat_fail_cnt got=%0d want=255", fail_w[1]); end
        total++; if (pass_w[1] !== 1'b0) begin bad++; $display("[TB] FAIL sat_pass got=%b want=0", pass_w[1]); end
        @(negedge tck);
    endtask

    task automatic test_abort();
        int n;
        start_pulse(0);
        n = 0;
        while (!(pidx_w[0] == 5'd2 && sdr_w[0]) && n < 1000) begin
            @(negedge tck);
            n++;
        end
        total++; if (!(pidx_w[0] == 5'd2 && sdr_w[0])) begin bad++; $display("[TB] FAIL abort_reach_pat2 got_idx=%0d want=2", pidx_w[0]); end
        repeat (5) @(negedge tck);
        abort_r[0] = 1'b1;
        @(negedge tck);
        abort_r[0] = 1'b0;
        total++; if (tlr_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL abort_tlr got=%b want=1", tlr_w[0]); end
        total++; if (pidx_w[0] !== 5'd0) begin bad++; $display("[TB] FAIL abort_pat_idx got=%0d want=0", pidx_w[0]); end
        @(negedge tck);
        total++; if (done_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL abort_done got=%b want=1", done_w[0]); end
        total++; if (pass_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL abort_pass got=%b want=0", pass_w[0]); end
        @(negedge tck);
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy_after got=%b want=0", busy_w[0]); end
        total++; if (pass_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL abort_pass_sticky got=%b want=0", pass_w[0]); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_pulse(0);
        lat = 1;
        while (!done_w[0] && lat < 1000) begin
            start_r[0] = (lat == 10 || lat == 100 || lat == 184);
            @(negedge tck);
            lat++;
        end
        start_r[0] = 1'b0;
        total++; if (lat != 186) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=186", lat); end
        total++; if (pass_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pass got=%b want=1", pass_w[0]); end
        start_r[0] = 1'b1;
        @(negedge tck);
        start_r[0] = 1'b0;
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_start_in_done got=%b want=0", busy_w[0]); end
        @(negedge tck);
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got=%b want=0", busy_w[0]); end
    endtask

    task automatic test_trst_mid_run();
        int n, dones, lat; bit to;
        start_pulse(0);
        n = 0;
        while (!(busy_w[0] && !sdr_w[0] && !tlr_w[0] && !com_w[0] && !done_w[0]) && n < 1000) begin
            @(negedge tck);
            n++;
        end
        total++; if (sdr_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL trst_reach_settle got_busy=%b want=1", busy_w[0]); end
        trst_n = 1'b0;
        @(negedge tck);
        trst_n = 1'b1;
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL trst_busy got=%b want=0", busy_w[0]); end
        total++; if (pass_w[0] !== 1'b0) begin bad++; $display("[TB] FAIL trst_pass got=%b want=0", pass_w[0]); end
        total++; if (pidx_w[0] !== 5'd0) begin bad++; $display("[TB] FAIL trst_pat_idx got=%0d want=0", pidx_w[0]); end
        total++; if (fail_w[0] !== 8'd0) begin bad++; $display("[TB] FAIL trst_fail_cnt got=%0d want=0", fail_w[0]); end
        total++; if ({tlr_w[0], sdr_w[0], sh_w[0], com_w[0], si_w[0]} !== 5'b0) begin
            bad++; $display("[TB] FAIL trst_ctrl got=%b want=00000", {tlr_w[0], sdr_w[0], sh_w[0], com_w[0], si_w[0]});
        end
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            if (done_w[0]) dones++;
            @(negedge tck);
        end
        total++; if (dones != 0) begin bad++; $display("[TB] FAIL trst_no_done got=%0d want=0", dones); end
        start_pulse(0);
        wait_done(0, 1, lat, to);
        total++; if (to || lat != 186) begin bad++; $display("[TB] FAIL trst_rerun_latency got=%0d want=186", lat); end
        total++; if (pass_w[0] !== 1'b1) begin bad++; $display("[TB] FAIL trst_rerun_pass got=%b want=1", pass_w[0]); end
        @(negedge tck);
    endtask

    initial begin
        trst_n  = 1'b0;
        start_r = 2'b00;
        abort_r = 2'b00;
        stim_rom[0] = 16'hA5C3;
        stim_rom[1] = 16'h0000;
        stim_rom[2] = 16'hFFFF;
        stim_rom[3] = 16'h1234;
        stim_rom[4] = 16'h8001;
        stim_rom[5] = 16'h5A5A;
        stim_rom[6] = 16'h0F0F;
        stim_rom[7] = 16'hDEAD;
        for (int i = 8; i < 32; i++) stim_rom[i] = 16'(i * 16'h1357) ^ 16'hBEEF;
        for (int p = 0; p < 32; p++) begin
            gold_rom[0][p] = exp_gold(stim_rom[p]);
            gold_rom[1][p] = ~exp_gold(stim_rom[p]);
        end

        test_reset();
        test_loopback();
        test_gold_flip();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_trst_mid_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
